bus_responder: RTL and testbench



---
 rtl/bus_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_bus_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// bus_responder: memory-bus target for the funnyarch control unit.
// Word-addressed RAM at 0x0000_0000 plus an MMIO window at 0xFFFF_0000
// (TXDATA) and 0xFFFF_0004 (STATUS) fronting a UART transmit FIFO and
// serializer.
//
// Build option: BUS_RESPONDER_UART_EN
//   defined   -> TX FIFO, serializer and STATUS register are built.
//   undefined -> no UART logic; tx idles high, TXDATA writes are dropped,
//                STATUS reads 0. RAM behaviour is identical in both builds.
//
// Serializer states (only present with BUS_RESPONDER_UART_EN):
//   state    | meaning
//   ST_IDLE  | line high; pops the FIFO head on the first cycle it is non-empty
//   ST_START | start bit (low) for CLKS_PER_BIT cycles
//   ST_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   ST_STOP  | stop bit (high) for CLKS_PER_BIT cycles, then back to ST_IDLE

module bus_responder #(
    parameter int RAM_WORDS    = 1024,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    output logic [31:0] bus_rdata,
    output logic        tx
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic [31:0]   rdata_d;
    logic [31:0]   rdata_q;
    logic [1:0]    addr_lsb_unused;

    // Byte lanes within a word are not decoded; the bus is word-only.
    assign addr_lsb_unused = bus_addr[1:0];

    assign ram_idx = bus_addr[AW+1:2];
    assign ram_hit = (bus_addr[31:AW+2] == '0);

`ifdef BUS_RESPONDER_UART_EN

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [29:0]   TXDATA_WORD = 30'h3FFF_C000;
    localparam logic [29:0]   STATUS_WORD = 30'h3FFF_C001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } ser_state_e;

    logic          prev_we_q;
    logic          prev_we_d;
    logic [29:0]   prev_addr_q;
    logic [29:0]   prev_addr_d;
    logic          txdata_hit;
    logic          status_hit;
    logic          wr_evt;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic [31:0]   status_word;

    ser_state_e    state_q;
    logic [TW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    assign txdata_hit = (bus_addr[31:2] == TXDATA_WORD);
    assign status_hit = (bus_addr[31:2] == STATUS_WORD);

    // A held write only counts once; a new event needs a rising bus_we or a new word address.
    assign wr_evt = bus_we && (!prev_we_q || (bus_addr[31:2] != prev_addr_q));

    // Full is judged on the count before this cycle's pop, so a same-cycle pop never rescues a push.
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_req   = wr_evt && txdata_hit;
    assign push       = push_req && !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;

    assign status_word = {16'h0000, 8'(count_q), 5'b00000, ovf_q, fifo_empty, fifo_full};

    // Next-state for write-event history, FIFO pointers/count and the sticky overflow flag.
    always_comb begin
        prev_we_d   = bus_we;
        prev_addr_d = bus_addr[31:2];
        wr_ptr_d    = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d    = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        ovf_d       = ovf_q;
        if (push_req && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_evt && status_hit) begin
            ovf_d = 1'b0;
        end
    end

    // Control registers; a reset drops everything queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_we_q   <= 1'b0;
            prev_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            prev_we_q   <= prev_we_d;
            prev_addr_q <= prev_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus_wdata[7:0];
        end
    end

    // Serializer; tx is registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_q[rd_ptr_q];
                        baud_q  <= BIT_LAST;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    tx_q <= 1'b0;
                    if (baud_q == '0) begin
                        baud_q    <= BIT_LAST;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q - TW'(1);
                    end
                end
                ST_DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_q == '0) begin
                        baud_q  <= BIT_LAST;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - TW'(1);
                    end
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q - TW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx = tx_q;

`else

    assign tx = 1'b1;

`endif

    // RAM write port: writes on every cycle with bus_we high; repeats are harmless.
    always_ff @(posedge clk) begin
        if (bus_we && ram_hit) begin
            ram_q[ram_idx] <= bus_wdata;
        end
    end

    // Read mux; sees pre-edge state, so read-during-write returns the old word.
    always_comb begin
        rdata_d = '0;
        if (ram_hit) begin
            rdata_d = ram_q[ram_idx];
        end
`ifdef BUS_RESPONDER_UART_EN
        else if (status_hit) begin
            rdata_d = status_word;
        end
`endif
    end

    // Read data register: one cycle of latency on every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder. The stimulus process advances a
// behavioural model (RAM as an associative array, TX FIFO as a byte queue,
// serializer as a "busy until cycle N" timestamp) and queues the expected
// read data and UART frames; independent monitors compare bus_rdata after
// every edge and decode the tx line frame by frame.

module tb_bus_responder;

    localparam int RAM_WORDS  = 256;
    localparam int FIFO_DEPTH = 16;
    localparam int CPB        = 6;
    localparam int AW         = $clog2(RAM_WORDS);
    localparam int FRAME      = 10 * CPB;
    localparam logic [31:0] TXDATA_A = 32'hFFFF_0000;
    localparam logic [31:0] STATUS_A = 32'hFFFF_0004;
    localparam logic [29:0] TXDATA_W = 30'(TXDATA_A >> 2);
    localparam logic [29:0] STATUS_W = 30'(STATUS_A >> 2);

    logic        clk = 1'b1;
    logic        reset;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_rdata;
    logic        tx;

    always #5 clk = ~clk;

    bus_responder #(
        .RAM_WORDS    (RAM_WORDS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_rdata (bus_rdata),
        .tx        (tx)
    );

    typedef struct {
        bit          chk;
        logic [31:0] addr;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    rd_exp_t     rdq[$];
    frame_t      txq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;

    logic [31:0] ram_m [int];
    logic [7:0]  mq[$];
    bit          m_ovf    = 1'b0;
    bit          m_pwe    = 1'b0;
    logic [29:0] m_paddr  = '0;
    int          free_at  = 0;
    frame_t      last_fr;
    bit          last_valid = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Line level of a UART frame at bit slot k (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_level(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return d[k-1];
    endfunction

    function automatic logic model_tx(input int c);
        if (!last_valid || c < last_fr.start || c >= last_fr.start + FRAME) return 1'b1;
        return frame_level(last_fr.data, (c - last_fr.start) / CPB);
    endfunction

    task automatic model_reset();
        rd_exp_t e;
        e.chk = 1'b1;
        e.addr = bus_addr;
        e.val = '0;
        rdq.push_back(e);
        mq.delete();
        txq.delete();
        m_ovf = 1'b0;
        m_pwe = 1'b0;
        m_paddr = '0;
        free_at = 0;
        last_valid = 1'b0;
    endtask

    // One bus cycle of the reference model, evaluated with this cycle's inputs.
    task automatic model_cycle();
        rd_exp_t e;
        frame_t  fr;
        bit      evt;
        bit      full;
        int      idx;
        e.chk  = 1'b1;
        e.addr = bus_addr;
        e.val  = '0;
        idx = int'(bus_addr[AW+1:2]);
        if (bus_addr < 32'(RAM_WORDS * 4)) begin
            if (ram_m.exists(idx)) e.val = ram_m[idx];
            else e.chk = 1'b0;
        end
`ifdef BUS_RESPONDER_UART_EN
        else if (bus_addr[31:2] == STATUS_W) begin
            e.val = {16'h0000, 8'(mq.size()), 5'b00000, m_ovf, (mq.size() == 0), (mq.size() == FIFO_DEPTH)};
        end
`endif
        rdq.push_back(e);
        evt = bus_we && (!m_pwe || (bus_addr[31:2] != m_paddr));
`ifdef BUS_RESPONDER_UART_EN
        full = (mq.size() == FIFO_DEPTH);
        if (cyc >= free_at && mq.size() > 0) begin
            fr.data  = mq.pop_front();
            fr.start = cyc + 2;
            txq.push_back(fr);
            last_fr    = fr;
            last_valid = 1'b1;
            free_at    = cyc + FRAME + 1;
        end
        if (evt && bus_addr[31:2] == TXDATA_W) begin
            if (full) m_ovf = 1'b1;
            else mq.push_back(bus_wdata[7:0]);
        end else if (evt && bus_addr[31:2] == STATUS_W) begin
            m_ovf = 1'b0;
        end
`else
        full = 1'b0;
        if (evt && full) m_ovf = 1'b1;
`endif
        if (bus_we && bus_addr < 32'(RAM_WORDS * 4)) ram_m[idx] = bus_wdata;
        m_pwe   = bus_we;
        m_paddr = bus_addr[31:2];
    endtask

    // Drive one cycle at the falling edge; inj asserts reset asynchronously mid-cycle.
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit rst, input bit inj);
        @(negedge clk);
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        if (inj) begin
            #1;
            check("tx_before_reset", {31'h0, tx}, {31'h0, model_tx(cyc)});
            reset = 1'b1;
            #1;
            check("tx_async_reset", {31'h0, tx}, 32'h1);
        end else begin
            reset = rst;
        end
        if (reset) model_reset();
        else model_cycle();
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, STATUS_A, 32'h0, 1'b0, 1'b0);
    endtask

    // Run until the model says every queued byte has left the line, then confirm the receiver saw them all.
    task automatic drain();
        int guard;
        guard = 0;
        while ((mq.size() > 0 || cyc < free_at + 3) && guard < 20000) begin
            step(1'b0, STATUS_A, 32'h0, 1'b0, 1'b0);
            guard++;
        end
        check("tx_frames_pending", 32'(txq.size()), 32'h0);
    endtask

    // Read-data monitor: one expectation per edge.
    always @(posedge clk) begin
        rd_exp_t e;
        #1;
        if (mon_en) begin
            if (rdq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rdata_queue_empty: got %h want none queued", bus_rdata);
            end else begin
                e = rdq.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (bus_rdata !== e.val) begin
                        n_fail++;
                        $display("FAIL rdata addr=%h: got %h want %h (cycle %0d)", e.addr, bus_rdata, e.val, cyc);
                    end
                end
            end
        end
    end

    // UART receiver: a low line starts a frame; every cycle of it is compared to the expected level.
    frame_t     rx_exp;
    int         rx_t    = 0;
    bit         rx_busy = 1'b0;
    bit         rx_bad  = 1'b0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        if (reset) begin
            rx_busy = 1'b0;
        end else begin
            if (!rx_busy && tx !== 1'b1) begin
                rx_busy = 1'b1;
                rx_t    = 0;
                rx_bad  = 1'b0;
                rx_byte = '0;
                if (txq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: got line low at cycle %0d want idle high", cyc);
                    rx_exp.data  = '0;
                    rx_exp.start = cyc;
                end else begin
                    rx_exp = txq.pop_front();
                    check("tx_start_cycle", 32'(cyc), 32'(rx_exp.start));
                end
            end
            if (rx_busy) begin
                if (tx !== frame_level(rx_exp.data, rx_t / CPB)) rx_bad = 1'b1;
                if ((rx_t % CPB) == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= 8)
                    rx_byte[rx_t / CPB - 1] = tx;
                rx_t++;
                if (rx_t == FRAME) begin
                    rx_busy = 1'b0;
                    check("tx_frame", {23'h0, rx_bad, rx_byte}, {24'h0, rx_exp.data});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of stimulus want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sel;
        int          hold;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        int          guard;

        reset     = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // RAM: held write, aliased byte address, unmapped read.
        repeat (3) step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h13, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        step(1'b0, TXDATA_A, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'(RAM_WORDS * 4), 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 32'(i * 4 + $urandom_range(0, 3)), 32'h0, 1'b0, 1'b0);

        // Single TXDATA write held three cycles: exactly one frame.
        repeat (3) step(1'b1, TXDATA_A, 32'h0000_0055, 1'b0, 1'b0);
        drain();

        // Fill past capacity while the serializer is busy.
        for (int i = 0; i < 18; i++) begin
            step(1'b1, TXDATA_A, 32'(8'h30 + i), 1'b0, 1'b0);
            step(1'b0, TXDATA_A, 32'h0, 1'b0, 1'b0);
        end
        idle(4);
        // Held write moving from TXDATA to STATUS: two events, the second clears overflow.
        step(1'b1, TXDATA_A, 32'h0000_00AB, 1'b0, 1'b0);
        step(1'b1, STATUS_A, 32'h0, 1'b0, 1'b0);
        idle(3);
        drain();
        step(1'b1, TXDATA_A, 32'h0000_003C, 1'b0, 1'b0);
        step(1'b1, STATUS_A, 32'h0, 1'b0, 1'b0);
        idle(2);
        drain();

        // Reset in the middle of a data bit with three bytes still queued.
        step(1'b1, TXDATA_A, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, TXDATA_A, 32'h0000_00A1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, TXDATA_A, 32'h0000_00B2, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, TXDATA_A, 32'h0000_00C3, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        guard = 0;
        while (!(last_valid && cyc >= last_fr.start + 2 * CPB + 1) && guard < 3 * CPB) begin
            step(1'b0, STATUS_A, 32'h0, 1'b0, 1'b0);
            guard++;
        end
        step(1'b0, STATUS_A, 32'h0, 1'b0, 1'b1);
        repeat (2) step(1'b0, STATUS_A, 32'h0, 1'b1, 1'b0);
        idle(3);
        drain();

        // Randomized traffic over RAM, both MMIO registers and unmapped space.
        for (int i = 0; i < 500; i++) begin
            sel  = $urandom_range(0, 9);
            hold = $urandom_range(1, 3);
            we   = ($urandom_range(0, 2) == 0);
            wd   = $urandom;
            if (sel <= 4) begin
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            end else if (sel <= 6) begin
                a = TXDATA_A | 32'($urandom_range(0, 3));
            end else if (sel == 7) begin
                a = STATUS_A;
            end else if (sel == 8) begin
                a = 32'(RAM_WORDS * 4) + 32'($urandom_range(0, 255) * 4);
            end else begin
                a = 32'hFFFF_0008 + 32'($urandom_range(0, 3) * 4);
            end
            for (int h = 0; h < hold; h++) step(we, a, wd, 1'b0, 1'b0);
        end
        drain();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
